// File: rtl/uart_frame_responder.sv
// Register-access responder for a byte-oriented UART link: parses SOF/CMD/ADDR/DATA/CHK
// request frames from the RX FIFO, drives a small register bus and answers with SOF/STATUS/RDATA.
module uart_frame_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter logic [7:0]  REQ_SOF        = 8'hA5,
  parameter logic [7:0]  RSP_SOF        = 8'h5A
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_rd,
  input  logic       i_tx_rdy,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_data,
  output logic       o_bus_wr,
  output logic       o_bus_rd,
  output logic [3:0] o_bus_addr,
  output logic [7:0] o_bus_wdata,
  input  logic [7:0] i_bus_rdata,
  output logic       o_busy,
  output logic [7:0] o_err_cnt
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_CHK = 8'h01;
  localparam logic [7:0] ST_BAD_CMD = 8'h02;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_CMD  = 4'd1,
    GET_ADDR = 4'd2,
    GET_DATA = 4'd3,
    GET_CHK  = 4'd4,
    EXEC     = 4'd5,
    BUS_WAIT = 4'd6,
    TX_SOF   = 4'd7,
    TX_STAT  = 4'd8,
    TX_DATA  = 4'd9
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             gap_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       cmd_r;
  logic [7:0]       addr_r;
  logic [7:0]       data_r;
  logic [7:0]       chk_r;
  logic [7:0]       status_r;
  logic [7:0]       rdata_r;
  logic [7:0]       err_r;

  logic             payload_s;
  logic             timeout_s;
  logic             rx_take_s;
  logic             tx_take_s;
  logic             rx_pop_s;
  logic             tx_push_s;
  logic             bus_wr_s;
  logic             bus_rd_s;
  logic             frame_err_s;
  logic [7:0]       exec_status_s;
  logic [7:0]       tx_byte_s;

  // Next-state decode, FIFO/bus strobes and frame evaluation
  always_comb begin
    state_s       = state_r;
    rx_pop_s      = 1'b0;
    tx_push_s     = 1'b0;
    bus_wr_s      = 1'b0;
    bus_rd_s      = 1'b0;
    frame_err_s   = 1'b0;
    exec_status_s = ST_OK;
    tx_byte_s     = 8'h00;
    payload_s     = (state_r == GET_CMD) || (state_r == GET_ADDR) ||
                    (state_r == GET_DATA) || (state_r == GET_CHK);
    // Strobes stay quiet during reset and for one gap cycle after each handshake
    rx_take_s     = i_rx_valid && !gap_r && !i_arst;
    tx_take_s     = i_tx_rdy && !gap_r && !i_arst;
    if (payload_s && (cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (rx_take_s) begin
          rx_pop_s = 1'b1;
          if (i_rx_data == REQ_SOF) begin
            state_s = GET_CMD;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
        if (timeout_s) begin
          state_s = IDLE;
        end else if (rx_take_s) begin
          rx_pop_s = 1'b1;
          case (state_r)
            GET_CMD:  state_s = GET_ADDR;
            GET_ADDR: state_s = GET_DATA;
            GET_DATA: state_s = GET_CHK;
            default:  state_s = EXEC;
          endcase
        end else begin
          state_s = state_r;
        end
      end
      EXEC: begin
        // Checksum takes priority over command decoding
        if (frame_chk(cmd_r, addr_r, data_r) != chk_r) begin
          exec_status_s = ST_BAD_CHK;
          frame_err_s   = 1'b1;
          state_s       = TX_SOF;
        end else if (cmd_r == CMD_WR) begin
          bus_wr_s = 1'b1;
          state_s  = TX_SOF;
        end else if (cmd_r == CMD_RD) begin
          bus_rd_s = 1'b1;
          state_s  = BUS_WAIT;
        end else begin
          exec_status_s = ST_BAD_CMD;
          frame_err_s   = 1'b1;
          state_s       = TX_SOF;
        end
      end
      BUS_WAIT: begin
        state_s = TX_SOF;
      end
      TX_SOF: begin
        tx_byte_s = RSP_SOF;
        if (tx_take_s) begin
          tx_push_s = 1'b1;
          state_s   = TX_STAT;
        end else begin
          state_s = TX_SOF;
        end
      end
      TX_STAT: begin
        tx_byte_s = status_r;
        if (tx_take_s) begin
          tx_push_s = 1'b1;
          state_s   = TX_DATA;
        end else begin
          state_s = TX_STAT;
        end
      end
      TX_DATA: begin
        tx_byte_s = rdata_r;
        if (tx_take_s) begin
          tx_push_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = TX_DATA;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, handshake gap, inter-byte timer, frame fields and error counter
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r  <= IDLE;
      gap_r    <= 1'b0;
      cnt_r    <= '0;
      cmd_r    <= 8'h00;
      addr_r   <= 8'h00;
      data_r   <= 8'h00;
      chk_r    <= 8'h00;
      status_r <= 8'h00;
      rdata_r  <= 8'h00;
      err_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      gap_r   <= rx_pop_s || tx_push_s;

      if (!payload_s || rx_pop_s || timeout_s) begin
        cnt_r <= '0;
      end else if (!i_rx_valid) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      if (rx_pop_s) begin
        case (state_r)
          GET_CMD:  cmd_r  <= i_rx_data;
          GET_ADDR: addr_r <= i_rx_data;
          GET_DATA: data_r <= i_rx_data;
          GET_CHK:  chk_r  <= i_rx_data;
          default:  cmd_r  <= cmd_r;
        endcase
      end

      if (state_r == EXEC) begin
        status_r <= exec_status_s;
        rdata_r  <= 8'h00;
      end else if (state_r == BUS_WAIT) begin
        rdata_r <= i_bus_rdata;
      end else begin
        rdata_r <= rdata_r;
      end

      if (timeout_s || frame_err_s) begin
        err_r <= sat_inc(err_r);
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign o_rx_rd     = rx_pop_s;
  assign o_tx_wr     = tx_push_s;
  assign o_tx_data   = tx_byte_s;
  assign o_bus_wr    = bus_wr_s;
  assign o_bus_rd    = bus_rd_s;
  assign o_bus_addr  = addr_r[3:0];
  assign o_bus_wdata = data_r;
  assign o_busy      = (state_r != IDLE);
  assign o_err_cnt   = err_r;

endmodule

// File: tb/tb_uart_frame_responder.sv
// Scoreboard bench for uart_frame_responder: FIFO/bus models drive the DUT, a frame-level
// reference model queues expected TX bytes and bus strobes, a monitor pops and compares.
module tb_uart_frame_responder;

  localparam int unsigned TO = 50;

  logic       sim_clk = 1'b0;
  logic       arst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic       tx_rdy;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       bus_wr;
  logic       bus_rd;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       busy;
  logic [7:0] err_cnt;

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  logic [12:0] exp_bus[$];
  logic [7:0]  slave_mem[16];
  logic [7:0]  ref_mem[16];
  logic [7:0]  ref_err = 8'h00;
  int          checks = 0;
  int          failures = 0;
  int          hold_cnt = 0;
  int          tx_pos = 0;
  bit          bp_arm = 1'b0;
  bit          rd_seen = 1'b0;
  int          rx_gate_pct = 100;
  int          tx_rdy_pct = 100;

  always #5 sim_clk = ~sim_clk;

  assign bus_rdata = slave_mem[bus_addr];

  uart_frame_responder #(.TIMEOUT_CYCLES(TO), .REQ_SOF(8'hA5), .RSP_SOF(8'h5A)) dut (
    .i_clk(sim_clk), .i_arst(arst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_rd(rx_rd), .i_tx_rdy(tx_rdy), .o_tx_wr(tx_wr), .o_tx_data(tx_data),
    .o_bus_wr(bus_wr), .o_bus_rd(bus_rd), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata), .o_busy(busy), .o_err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump_err();
    if (ref_err != 8'hFF) ref_err = ref_err + 8'd1;
  endtask

  // Reference model: evaluates a whole request frame from the protocol rules
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
    logic [7:0] st;
    logic [7:0] rd;
    rxq.push_back(8'hA5);
    rxq.push_back(cmd);
    rxq.push_back(addr);
    rxq.push_back(data);
    rxq.push_back(chk);
    if (chk != (cmd ^ addr ^ data)) begin
      st = 8'h01; rd = 8'h00; bump_err();
    end else if (cmd == 8'h01) begin
      st = 8'h00; rd = 8'h00;
      ref_mem[addr[3:0]] = data;
      exp_bus.push_back({1'b1, addr[3:0], data});
    end else if (cmd == 8'h02) begin
      st = 8'h00; rd = ref_mem[addr[3:0]];
      exp_bus.push_back({1'b0, addr[3:0], 8'h00});
    end else begin
      st = 8'h02; rd = 8'h00; bump_err();
    end
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(st);
    exp_tx.push_back(rd);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((rxq.size() > 0 || exp_tx.size() > 0 || exp_bus.size() > 0 || busy) && n < budget) begin
      @(negedge sim_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle timed out rxq=%0d exp_tx=%0d exp_bus=%0d busy=%0b",
               rxq.size(), exp_tx.size(), exp_bus.size(), busy);
    end
    @(negedge sim_clk);
    check("err_cnt", {24'h0, err_cnt}, {24'h0, ref_err});
  endtask

  // Monitor: compares every TX push and bus strobe against the scoreboard queues
  initial begin
    logic [7:0]  e;
    logic [12:0] eb;
    forever begin
      @(negedge sim_clk);
      rd_seen = rx_rd;
      if (hold_cnt > 0) check("no_tx_during_hold", {31'h0, tx_wr}, 32'h0);
      if (tx_wr) begin
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_tx actual=%0h expected=none", tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", {24'h0, tx_data}, {24'h0, e});
        end
        if (tx_pos == 0 && bp_arm) begin
          hold_cnt = 20;
          bp_arm = 1'b0;
        end
        tx_pos = (tx_pos + 1) % 3;
      end
      if (bus_wr || bus_rd) begin
        check("bus_strobe_excl", {31'h0, bus_wr & bus_rd}, 32'h0);
        if (exp_bus.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_bus actual=wr%0b rd%0b addr=%0h", bus_wr, bus_rd, bus_addr);
        end else begin
          eb = exp_bus.pop_front();
          check("bus_op", {19'h0, bus_wr, bus_addr, (bus_wr ? bus_wdata : 8'h00)}, {19'h0, eb});
        end
        if (bus_wr) slave_mem[bus_addr] = bus_wdata;
      end
    end
  end

  // FIFO driver: pops the RX model after each observed pop, randomises valid/ready
  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_rdy   = 1'b0;
    forever begin
      @(posedge sim_clk);
      #1;
      if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
      if (hold_cnt > 0) begin
        hold_cnt--;
        tx_rdy = 1'b0;
      end else begin
        tx_rdy = ($urandom_range(99) < tx_rdy_pct);
      end
      rx_valid = (rxq.size() > 0) && ($urandom_range(99) < rx_gate_pct);
      rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  initial begin
    logic [7:0] c, a, d, k, g;
    int n;
    arst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[7] = 8'h3C;
    ref_mem[7]   = 8'h3C;
    repeat (3) @(negedge sim_clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {24'h0, err_cnt}, 32'h0);
    check("rst_strobes", {28'h0, rx_rd, tx_wr, bus_wr, bus_rd}, 32'h0);
    check("rst_data", {12'h0, tx_data, bus_addr, bus_wdata}, 32'h0);
    @(posedge sim_clk); #1 arst = 1'b0;

    send_frame(8'h01, 8'h03, 8'hC3, 8'hC1);
    wait_idle(200);
    send_frame(8'h02, 8'h07, 8'h00, 8'h05);
    wait_idle(200);
    send_frame(8'h01, 8'h03, 8'hC3, 8'h00);
    wait_idle(200);
    send_frame(8'h09, 8'h00, 8'h00, 8'h09);
    wait_idle(200);
    rxq.push_back(8'h11);
    rxq.push_back(8'h22);
    send_frame(8'h02, 8'h01, 8'h00, 8'h03);
    wait_idle(200);

    // Backpressure: TX ready held low for 20 cycles right after the SOF push
    bp_arm = 1'b1;
    send_frame(8'h02, 8'h03, 8'h55, 8'h54);
    wait_idle(300);

    // Inter-byte timeout after a partial frame
    rxq.push_back(8'hA5);
    rxq.push_back(8'h01);
    repeat (60) @(negedge sim_clk);
    bump_err();
    check("timeout_idle", {31'h0, busy}, 32'h0);
    check("timeout_err", {24'h0, err_cnt}, {24'h0, ref_err});
    send_frame(8'h01, 8'h0A, 8'h5E, 8'h55);
    wait_idle(200);

    // Reset in GET_ADDR abandons the frame
    rxq.push_back(8'hA5);
    rxq.push_back(8'h01);
    n = 0;
    while (rxq.size() > 0 && n < 100) begin @(negedge sim_clk); n++; end
    repeat (3) @(negedge sim_clk);
    check("midframe_busy", {31'h0, busy}, 32'h1);
    @(posedge sim_clk); #1 arst = 1'b1;
    rxq.push_back(8'h03);
    rxq.push_back(8'hC3);
    rxq.push_back(8'hC1);
    ref_err = 8'h00;
    repeat (3) @(negedge sim_clk);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_rx_rd", {31'h0, rx_rd}, 32'h0);
    check("arst_err", {24'h0, err_cnt}, 32'h0);
    check("arst_data", {12'h0, tx_data, bus_addr, bus_wdata}, 32'h0);
    @(posedge sim_clk); #1 arst = 1'b0;
    wait_idle(200);

    // Randomised mixed traffic with RX gaps and TX backpressure
    rx_gate_pct = 70;
    tx_rdy_pct  = 60;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(3) == 0) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        rxq.push_back(g);
      end
      a = 8'($urandom);
      d = 8'($urandom);
      case ($urandom_range(3))
        0: c = 8'h01;
        1: c = 8'h02;
        2: begin c = 8'h01 + 8'($urandom_range(1)); end
        default: begin c = 8'($urandom); if (c == 8'h01 || c == 8'h02) c = 8'h80; end
      endcase
      k = c ^ a ^ d;
      if ($urandom_range(4) == 0) k = k ^ (8'($urandom_range(254)) + 8'd1);
      send_frame(c, a, d, k);
    end
    wait_idle(5000);

    // Error counter saturation
    rx_gate_pct = 100;
    tx_rdy_pct  = 100;
    for (int f = 0; f < 260; f++) send_frame(8'h33, 8'h00, 8'h00, 8'h33);
    wait_idle(20000);
    check("err_saturated", {24'h0, err_cnt}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_responder.md
UART_FRAME_RESPONDER -- requirements
Module: uart_frame_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100_000, SHALL set the inter-byte timeout in clock cycles (1 ms at 100 MHz).
REQ-002 Parameter REQ_SOF, default 8'hA5, SHALL be the request start-of-frame byte.
REQ-003 Parameter RSP_SOF, default 8'h5A, SHALL be the response start-of-frame byte.
REQ-004 i_clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 i_arst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 i_rx_data  in  8  SHALL be the head byte of the transceiver RX FIFO.
REQ-007 i_rx_valid  in  1  SHALL indicate that the RX FIFO is non-empty.
REQ-008 o_rx_rd  out  1  SHALL be the one-cycle RX FIFO pop pulse.
REQ-009 i_tx_rdy  in  1  SHALL indicate that the TX FIFO can accept a byte.
REQ-010 o_tx_wr  out  1  SHALL be the one-cycle TX FIFO push pulse.
REQ-011 o_tx_data  out  8  SHALL be the byte pushed with o_tx_wr.
REQ-012 o_bus_wr, o_bus_rd  out  1 each  SHALL be one-cycle register-bus strobes.
REQ-013 o_bus_addr  out  4  SHALL be the register address, held stable from strobe until response start.
REQ-014 o_bus_wdata  out  8  SHALL be the register write data.
REQ-015 i_bus_rdata  in  8  SHALL be the read data, valid exactly one cycle after o_bus_rd.
REQ-016 o_busy  out  1  SHALL be high in every state except IDLE.
REQ-017 o_err_cnt  out  8  SHALL be a saturating count of checksum, command and timeout errors.

Function
REQ-018 Request frame SHALL be the bytes SOF, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
  - ADDR[3:0] selects the register; ADDR[7:4] is ignored.
  - DATA is ignored for reads.
REQ-019 Response frame SHALL be the bytes RSP_SOF, STATUS, RDATA, sent in that order.
  - STATUS: 8'h00 OK, 8'h01 bad checksum, 8'h02 bad command.
  - RDATA is the read value for CMD 8'h02 and 8'h00 otherwise.
REQ-020 CMD 8'h01 SHALL be a register write and CMD 8'h02 a register read; every other CMD value is a bad command.
REQ-021 RX pop handshake:
  - With i_rx_valid=1, the FSM samples i_rx_data and pulses o_rx_rd for exactly one cycle in the same cycle.
  - i_rx_valid is then ignored for one gap cycle.
REQ-022 TX push handshake:
  - With i_tx_rdy=1, the FSM pulses o_tx_wr for one cycle with o_tx_data valid.
  - i_tx_rdy is then ignored for one gap cycle.
REQ-023 State machine SHALL have the states IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, BUS_WAIT, TX_SOF, TX_STAT and TX_DATA.
REQ-024 IDLE SHALL pop and discard every byte not equal to REQ_SOF; on a REQ_SOF byte it SHALL go to GET_CMD.
REQ-025 GET_CMD through GET_CHK SHALL each consume one byte and advance to the next state; GET_CHK goes to EXEC.
REQ-026 EXEC SHALL take exactly one cycle and act as follows:
  - Checksum mismatch: STATUS 8'h01, no bus strobe, go to TX_SOF.
  - Else, bad command: STATUS 8'h02, no bus strobe, go to TX_SOF.
  - Else, write: pulse o_bus_wr, STATUS 8'h00, go to TX_SOF.
  - Else, read: pulse o_bus_rd, go to BUS_WAIT.
  - Checksum is checked before command.
REQ-027 BUS_WAIT SHALL capture i_bus_rdata on its single cycle and then go to TX_SOF.
REQ-028 TX_SOF, TX_STAT and TX_DATA SHALL each push one byte per REQ-022; TX_DATA returns to IDLE.
  - TX states wait indefinitely for i_tx_rdy, with no timeout.
REQ-029 Timeout counter:
  - Clears on every popped byte and on entry to GET_CMD.
  - Counts while in GET_CMD..GET_CHK with i_rx_valid=0.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE with no response and o_err_cnt increments.
REQ-030 A bad checksum or bad command SHALL increment o_err_cnt once per frame, saturating at 8'hFF.
REQ-031 An REQ_SOF byte received mid-frame SHALL be treated as ordinary payload, with no resynchronisation.
REQ-032 Latency from the CHK pop to the first o_tx_wr SHALL be 2 cycles for write/error frames and 3 cycles for reads when i_tx_rdy=1.

Reset
REQ-033 While i_arst=1, the FSM SHALL be in IDLE.
  - o_rx_rd, o_tx_wr, o_bus_wr, o_bus_rd, o_busy = 0.
  - o_tx_data, o_bus_addr, o_bus_wdata, o_err_cnt = 0.
  - Timeout counter = 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately; no partial response is emitted after release.
REQ-035 The first byte popped after reset release SHALL be handled in IDLE.

Verification
REQ-036 Write: A5 01 03 C3 C1 -> one o_bus_wr with addr 3 and wdata C3; TX bytes 5A 00 00; o_err_cnt=0.
REQ-037 Read: A5 02 07 00 05 with i_bus_rdata=3C -> one o_bus_rd with addr 7; TX bytes 5A 00 3C.
REQ-038 Bad checksum: A5 01 03 C3 00 -> no bus strobe; TX 5A 01 00; o_err_cnt=1. Bad command: A5 09 00 00 09 -> TX 5A 02 00; o_err_cnt=2.
REQ-039 Garbage then frame: 11 22 A5 02 01 00 03 -> 11 and 22 popped and discarded; read of addr 1 is answered.
REQ-040 Timeout with TIMEOUT_CYCLES=50: send A5 01, then stall RX for 60 cycles -> return to IDLE, no TX, o_err_cnt=1; the next full frame is answered normally.
REQ-041 Backpressure and reset:
  - Hold i_tx_rdy=0 for 20 cycles during TX_STAT -> no o_tx_wr until i_tx_rdy=1, byte order preserved.
  - Assert i_arst during GET_ADDR -> all outputs reset; no response after release.
